// File: rtl/k007232_seq_if.sv
// Command handshake and device write-port bundle for the 007232 register sequencer.
// master = command source / device side observer, slave = the sequencer.
interface k007232_seq_if;
   logic        CMD_VALID;
   logic        CMD_READY;
   logic [1:0]  CMD_OP;
   logic        CMD_CH;
   logic [11:0] CMD_PITCH;
   logic [1:0]  CMD_MODE;
   logic [16:0] CMD_ADDR;
   logic [7:0]  CMD_VOL;
   logic        CMD_LOOP;
   logic [3:0]  AB;
   logic [7:0]  DB;
   logic        DB_OE;
   logic        DACS;
   logic        DONE;

   modport master (
      output CMD_VALID, CMD_OP, CMD_CH, CMD_PITCH, CMD_MODE, CMD_ADDR, CMD_VOL, CMD_LOOP,
      input  CMD_READY, AB, DB, DB_OE, DACS, DONE
   );

   modport slave (
      input  CMD_VALID, CMD_OP, CMD_CH, CMD_PITCH, CMD_MODE, CMD_ADDR, CMD_VOL, CMD_LOOP,
      output CMD_READY, AB, DB, DB_OE, DACS, DONE
   );
endinterface

// File: rtl/k007232_seq.sv
// Expands high-level channel commands into timed 007232 register writes
// (SETUP / STROBE / HOLD per write) with an active-low DACS strobe.
module k007232_seq #(
   parameter int unsigned STROBE_LEN = 2
) (
   input  logic         CLK,
   input  logic         RES,
   k007232_seq_if.slave bus
);
   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = 3;

   localparam logic [1:0] OP_START  = 2'd0;
   localparam logic [1:0] OP_RETRIG = 2'd1;
   localparam logic [1:0] OP_VOLUME = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic              ch_q, ch_d;
   logic [11:0]       pitch_q, pitch_d;
   logic [1:0]        mode_q, mode_d;
   logic [16:0]       addr_q, addr_d;
   logic [7:0]        vol_q, vol_d;
   logic [1:0]        loopsh_q, loopsh_d;
   logic [3:0]        ab_q, ab_d;
   logic [7:0]        db_q, db_d;
   logic              db_oe_q, db_oe_d;
   logic              dacs_q, dacs_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic [11:0]       word;
   logic [1:0]        loopsh_new;
   logic              last_wr;

   // {AB, DB} for write idx of a command; AB carries the device's inverted bit 0.
   function automatic logic [11:0] wr_word(
      input logic [1:0]       op,
      input logic             ch,
      input logic [IDX_W-1:0] idx,
      input logic [11:0]      pitch,
      input logic [1:0]       mode,
      input logic [16:0]      addr,
      input logic [7:0]       vol,
      input logic [1:0]       loopsh
   );
      logic [3:0] base;
      logic [3:0] n;
      logic [7:0] d;
      base = ch ? 4'd6 : 4'd0;
      n    = base;
      d    = 8'h00;
      case (op)
         OP_START: begin
            n = base + 4'(idx);
            case (idx)
               3'd0:    d = pitch[7:0];
               3'd1:    d = {2'b00, mode, pitch[11:8]};
               3'd2:    d = addr[7:0];
               3'd3:    d = addr[15:8];
               3'd4:    d = {7'b0, addr[16]};
               default: d = 8'h00;
            endcase
         end
         OP_RETRIG: n = base + 4'd5;
         OP_VOLUME: begin
            n = 4'd12;
            d = vol;
         end
         default: begin
            n = 4'd13;
            d = {6'b0, loopsh};
         end
      endcase
      return {n ^ 4'd1, d};
   endfunction

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
         ch_q     <= 1'b0;
         pitch_q  <= '0;
         mode_q   <= '0;
         addr_q   <= '0;
         vol_q    <= '0;
         loopsh_q <= 2'b00;
         ab_q     <= 4'h0;
         db_q     <= 8'h00;
         db_oe_q  <= 1'b0;
         dacs_q   <= 1'b1;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         ch_q     <= ch_d;
         pitch_q  <= pitch_d;
         mode_q   <= mode_d;
         addr_q   <= addr_d;
         vol_q    <= vol_d;
         loopsh_q <= loopsh_d;
         ab_q     <= ab_d;
         db_q     <= db_d;
         db_oe_q  <= db_oe_d;
         dacs_q   <= dacs_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
      end
   end

   // Outputs are computed one cycle ahead so every pin comes straight from a flop.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      ch_d       = ch_q;
      pitch_d    = pitch_q;
      mode_d     = mode_q;
      addr_d     = addr_q;
      vol_d      = vol_q;
      loopsh_d   = loopsh_q;
      ab_d       = ab_q;
      db_d       = db_q;
      db_oe_d    = db_oe_q;
      dacs_d     = dacs_q;
      ready_d    = ready_q;
      done_d     = 1'b0;
      word       = 12'h000;
      loopsh_new = loopsh_q;
      last_wr    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.CMD_VALID && ready_q) begin
               op_d    = bus.CMD_OP;
               ch_d    = bus.CMD_CH;
               pitch_d = bus.CMD_PITCH;
               mode_d  = bus.CMD_MODE;
               addr_d  = bus.CMD_ADDR;
               vol_d   = bus.CMD_VOL;
               if (bus.CMD_OP == 2'd3) begin
                  loopsh_new[bus.CMD_CH] = bus.CMD_LOOP;
               end
               loopsh_d = loopsh_new;
               word     = wr_word(bus.CMD_OP, bus.CMD_CH, '0, bus.CMD_PITCH, bus.CMD_MODE,
                                  bus.CMD_ADDR, bus.CMD_VOL, loopsh_new);
               idx_d    = '0;
               ab_d     = word[11:8];
               db_d     = word[7:0];
               db_oe_d  = 1'b1;
               ready_d  = 1'b0;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            cnt_d   = '0;
            dacs_d  = 1'b0;
            state_d = S_STROBE;
         end
         S_STROBE: begin
            if (cnt_q == CNT_W'(STROBE_LEN - 1)) begin
               dacs_d  = 1'b1;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HOLD: begin
            last_wr = (op_q != OP_START) || (idx_q == IDX_W'(5));
            if (!last_wr) begin
               idx_d   = idx_q + IDX_W'(1);
               word    = wr_word(op_q, ch_q, idx_q + IDX_W'(1), pitch_q, mode_q, addr_q,
                                 vol_q, loopsh_q);
               ab_d    = word[11:8];
               db_d    = word[7:0];
               state_d = S_SETUP;
            end else begin
               db_oe_d = 1'b0;
               ready_d = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.CMD_READY = ready_q;
   assign bus.AB        = ab_q;
   assign bus.DB        = db_q;
   assign bus.DB_OE     = db_oe_q;
   assign bus.DACS      = dacs_q;
   assign bus.DONE      = done_q;
endmodule

// File: tb/tb_k007232_seq.sv
// Bench for k007232_seq: drives commands, records the writes seen on the device
// port and compares them with a register-level model of the command expansion.
module tb_k007232_seq;
   logic CLK;
   logic RES;

   k007232_seq_if if0 ();
   k007232_seq_if if1 ();

   k007232_seq #(.STROBE_LEN(2)) dut0 (.CLK(CLK), .RES(RES), .bus(if0));
   k007232_seq #(.STROBE_LEN(1)) dut1 (.CLK(CLK), .RES(RES), .bus(if1));

   int          n_checks;
   int          n_fail;
   logic [1:0]  loopsh_m;
   logic [11:0] exp_q[$];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic push(input int reg_n, input int d);
      exp_q.push_back({4'(reg_n ^ 1), 8'(d)});
   endtask

   // Expected {AB,DB} writes for one command, straight from the register map.
   task automatic model(input logic [1:0] op, input logic ch, input logic [11:0] pitch,
                        input logic [1:0] mode, input logic [16:0] addr,
                        input logic [7:0] vol, input logic lp);
      int base, p, a;
      exp_q.delete();
      base = ch ? 6 : 0;
      p    = int'(pitch);
      a    = int'(addr);
      case (op)
         2'd0: begin
            push(base + 0, p % 256);
            push(base + 1, int'(mode) * 16 + p / 256);
            push(base + 2, a % 256);
            push(base + 3, (a / 256) % 256);
            push(base + 4, a / 65536);
            push(base + 5, 0);
         end
         2'd1: push(base + 5, 0);
         2'd2: push(12, int'(vol));
         default: begin
            loopsh_m[ch] = lp;
            push(13, int'(loopsh_m));
         end
      endcase
   endtask

   task automatic drive(input int sel, input logic v, input logic [1:0] op, input logic ch,
                        input logic [11:0] pitch, input logic [1:0] mode,
                        input logic [16:0] addr, input logic [7:0] vol, input logic lp);
      if (sel == 0) begin
         if0.CMD_VALID = v; if0.CMD_OP = op; if0.CMD_CH = ch; if0.CMD_PITCH = pitch;
         if0.CMD_MODE = mode; if0.CMD_ADDR = addr; if0.CMD_VOL = vol; if0.CMD_LOOP = lp;
      end else begin
         if1.CMD_VALID = v; if1.CMD_OP = op; if1.CMD_CH = ch; if1.CMD_PITCH = pitch;
         if1.CMD_MODE = mode; if1.CMD_ADDR = addr; if1.CMD_VOL = vol; if1.CMD_LOOP = lp;
      end
   endtask

   task automatic scramble(input int sel, input logic v);
      drive(sel, v, 2'($urandom), 1'($urandom), 12'($urandom), 2'($urandom),
            17'($urandom), 8'($urandom), 1'($urandom));
   endtask

   // Returns after the posedge on which the pending command is taken.
   task automatic wait_accept(input int sel);
      logic rdy;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         rdy = (sel == 0) ? if0.CMD_READY : if1.CMD_READY;
         if (rdy === 1'b1) begin
            @(posedge CLK);
            return;
         end
      end
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: CMD_READY never seen high within 200 cycles");
   endtask

   // Follows one command from its first SETUP cycle to its DONE cycle and checks it.
   task automatic trace(input int sel, input int sl, input string name);
      logic [3:0]  ab, sab;
      logic [7:0]  db, sdb;
      logic        dacs, prev, oe, dn, rdy, rdy_done, bad;
      logic [11:0] got[$];
      int          widths[$];
      int          low, done_k, want_k;
      low = 0; prev = 1'b1; done_k = -1; bad = 1'b0; sab = '0; sdb = '0; rdy_done = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge CLK);
         if (sel == 0) begin
            ab = if0.AB; db = if0.DB; dacs = if0.DACS; oe = if0.DB_OE; dn = if0.DONE;
            rdy = if0.CMD_READY;
         end else begin
            ab = if1.AB; db = if1.DB; dacs = if1.DACS; oe = if1.DB_OE; dn = if1.DONE;
            rdy = if1.CMD_READY;
         end
         if (k == 1) begin
            n_checks++;
            if ({oe, dacs, rdy} !== 3'b110) begin
               n_fail++;
               $display("FAIL %s first_setup: oe/dacs/ready=%b%b%b want 110", name, oe, dacs, rdy);
            end
         end
         if (dacs === 1'b0) begin
            if (low == 0) begin
               sab = ab; sdb = db;
            end else if (ab !== sab || db !== sdb) begin
               bad = 1'b1;
            end
            if (oe !== 1'b1) bad = 1'b1;
            low++;
         end else if (prev === 1'b0) begin
            if (ab !== sab || db !== sdb || oe !== 1'b1) bad = 1'b1;
            got.push_back({ab, db});
            widths.push_back(low);
            low = 0;
         end
         prev = dacs;
         if (dn === 1'b1) begin
            done_k = k; rdy_done = rdy;
            break;
         end
      end
      want_k = exp_q.size() * (sl + 2) + 1;
      n_checks++;
      if (done_k != want_k) begin
         n_fail++;
         $display("FAIL %s done_cycle: got %0d want %0d", name, done_k, want_k);
      end
      n_checks++;
      if (rdy_done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready_at_done: got %b want 1", name, rdy_done);
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL %s bus_stable: AB/DB/DB_OE moved during a write (got 1 want 0)", name);
      end
      n_checks++;
      if (got.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL %s write_count: got %0d want %0d", name, got.size(), exp_q.size());
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s write[%0d]: got AB=%0d DB=%h want AB=%0d DB=%h", name, i,
                     got[i][11:8], got[i][7:0], exp_q[i][11:8], exp_q[i][7:0]);
         end
         n_checks++;
         if (widths[i] != sl) begin
            n_fail++;
            $display("FAIL %s dacs_width[%0d]: got %0d want %0d", name, i, widths[i], sl);
         end
      end
   endtask

   task automatic run(input int sel, input int sl, input string name, input logic [1:0] op,
                      input logic ch, input logic [11:0] pitch, input logic [1:0] mode,
                      input logic [16:0] addr, input logic [7:0] vol, input logic lp);
      logic dn;
      if (sel == 0) model(op, ch, pitch, mode, addr, vol, lp);
      else begin
         exp_q.delete();
         model(op, ch, pitch, mode, addr, vol, lp);
      end
      @(negedge CLK);
      drive(sel, 1'b1, op, ch, pitch, mode, addr, vol, lp);
      wait_accept(sel);
      #1 scramble(sel, 1'b0);
      trace(sel, sl, name);
      @(negedge CLK);
      dn = (sel == 0) ? if0.DONE : if1.DONE;
      n_checks++;
      if (dn !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_pulse_width: DONE=%b one cycle later, want 0", name, dn);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RES = 1'b1;
      repeat (2) @(negedge CLK);
      RES = 1'b0;
      loopsh_m = 2'b00;
   endtask

   task automatic test_reset();
      logic seen_done;
      n_checks++;
      if ({if0.CMD_READY, if0.AB, if0.DB, if0.DB_OE, if0.DACS, if0.DONE} !== {1'b1, 12'h000, 3'b010}) begin
         n_fail++;
         $display("FAIL reset_state: ready=%b AB=%h DB=%h oe=%b dacs=%b done=%b want 1 0 00 0 1 0",
                  if0.CMD_READY, if0.AB, if0.DB, if0.DB_OE, if0.DACS, if0.DONE);
      end
      run(0, 2, "pre_reset_loop", 2'd3, 1'b1, 12'h0, 2'd0, 17'h0, 8'h0, 1'b1);
      model(2'd0, 1'b0, 12'h123, 2'd1, 17'h0ABCD, 8'h0, 1'b0);
      @(negedge CLK);
      drive(0, 1'b1, 2'd0, 1'b0, 12'h123, 2'd1, 17'h0ABCD, 8'h00, 1'b0);
      wait_accept(0);
      #1 scramble(0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (if0.DACS === 1'b0 && i > 8) break;
      end
      #2 RES = 1'b1;
      #1;
      n_checks++;
      if (if0.DACS !== 1'b1 || if0.DB_OE !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: dacs=%b oe=%b want 1 0", if0.DACS, if0.DB_OE);
      end
      seen_done = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         if (if0.DONE === 1'b1) seen_done = 1'b1;
      end
      RES = 1'b0;
      loopsh_m = 2'b00;
      repeat (4) begin
         @(negedge CLK);
         if (if0.DONE === 1'b1) seen_done = 1'b1;
      end
      n_checks++;
      if ({if0.CMD_READY, if0.AB, if0.DB, if0.DACS, if0.DB_OE} !== {1'b1, 12'h000, 2'b10}) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b AB=%h DB=%h dacs=%b oe=%b want 1 0 00 1 0",
                  if0.CMD_READY, if0.AB, if0.DB, if0.DACS, if0.DB_OE);
      end
      n_checks++;
      if (seen_done) begin
         n_fail++;
         $display("FAIL reset_no_done: DONE seen 1 want 0");
      end
      run(0, 2, "post_reset_loop", 2'd3, 1'b0, 12'h0, 2'd0, 17'h0, 8'h0, 1'b1);
   endtask

   task automatic test_start();
      run(0, 2, "start_ch1", 2'd0, 1'b1, 12'hABC, 2'b10, 17'h12345, 8'h00, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [11:0] p;
      logic [16:0] a;
      p = 12'($urandom);
      a = 17'($urandom);
      model(2'd0, 1'b0, p, 2'd3, a, 8'h00, 1'b0);
      @(negedge CLK);
      drive(0, 1'b1, 2'd0, 1'b0, p, 2'd3, a, 8'h00, 1'b0);
      wait_accept(0);
      #1 drive(0, 1'b1, 2'd1, 1'b0, 12'($urandom), 2'($urandom), 17'($urandom), 8'($urandom), 1'b1);
      trace(0, 2, "b2b_start");
      n_checks++;
      if (if0.CMD_VALID !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_valid_held: CMD_VALID=%b want 1", if0.CMD_VALID);
      end
      model(2'd1, 1'b0, 12'h0, 2'd0, 17'h0, 8'h00, 1'b0);
      @(posedge CLK);
      #1 scramble(0, 1'b0);
      trace(0, 2, "b2b_retrig");
   endtask

   task automatic test_loop();
      do_reset();
      run(0, 2, "loop_ch1_on", 2'd3, 1'b1, 12'h0, 2'd0, 17'h0, 8'h00, 1'b1);
      run(0, 2, "loop_ch0_on", 2'd3, 1'b0, 12'h0, 2'd0, 17'h0, 8'h00, 1'b1);
      run(0, 2, "loop_ch1_off", 2'd3, 1'b1, 12'h0, 2'd0, 17'h0, 8'h00, 1'b0);
   endtask

   task automatic test_volume();
      run(0, 2, "volume", 2'd2, 1'b1, 12'h0, 2'd0, 17'h0, 8'h5A, 1'b0);
   endtask

   task automatic test_strobe1();
      run(1, 1, "strobe1_start", 2'd0, 1'b0, 12'($urandom), 2'($urandom), 17'($urandom),
          8'h00, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge CLK);
         run(0, 2, "random", 2'($urandom), 1'($urandom), 12'($urandom), 2'($urandom),
             17'($urandom), 8'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      loopsh_m = 2'b00;
      RES      = 1'b1;
      drive(0, 1'b0, 2'd0, 1'b0, 12'h0, 2'd0, 17'h0, 8'h00, 1'b0);
      drive(1, 1'b0, 2'd0, 1'b0, 12'h0, 2'd0, 17'h0, 8'h00, 1'b0);
      repeat (3) @(negedge CLK);
      RES = 1'b0;
      test_reset();
      test_start();
      test_back_to_back();
      test_loop();
      test_volume();
      test_strobe1();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/k007232_seq.md
# k007232_seq

Register-write sequencer that drives the CPU-side write port of a 007232 PCM sound device. It accepts high-level channel commands (start, retrigger, volume, loop enable) through a valid/ready handshake and expands each command into a timed series of register writes on AB/DB with an active-low DACS strobe. It sits between the sound CPU model or a test driver and the 007232 core, and replaces hand-written register poking.

## Interface
- STROBE_LEN, default 2: DACS low width in CLK cycles, legal range 1..15.
- CLK  in  1  system clock; all state changes on the rising edge.
- RES  in  1  asynchronous reset, active-high.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block idle and able to accept a command.
- CMD_OP  in  2  0 = START, 1 = RETRIG, 2 = VOLUME, 3 = LOOP.
- CMD_CH  in  1  channel select, 0 = A, 1 = B.
- CMD_PITCH  in  12  prescaler reload value (START only).
- CMD_MODE  in  2  prescaler mode bits, become register bits [5:4] (START only).
- CMD_ADDR  in  17  sample start address (START only).
- CMD_VOL  in  8  volume byte (VOLUME only).
- CMD_LOOP  in  1  loop enable for CMD_CH (LOOP only).
- AB  out  4  device register address, pin-encoded.
- DB  out  8  write data.
- DB_OE  out  1  data bus drive enable.
- DACS  out  1  write strobe, active-low.
- DONE  out  1  one-cycle pulse when a command's last write completes.

## Operation
- Logical register n is presented as AB = n XOR 1, because the device inverts AB[0].
- Channel base B is 0 for channel A and 6 for channel B.
- START issues six writes in this order:
  - B+0: PITCH[7:0]
  - B+1: {2'b00, MODE, PITCH[11:8]}
  - B+2: ADDR[7:0]
  - B+3: ADDR[15:8]
  - B+4: {7'b0, ADDR[16]}
  - B+5: 8'h00 (trigger)
- RETRIG issues one write: B+5, data 8'h00.
- VOLUME issues one write: register 12, data CMD_VOL. The channel bit is ignored.
- LOOP updates the shadow bit LOOPSH[CMD_CH] with CMD_LOOP, then writes register 13 with {6'b0, LOOPSH} using the updated value.
- All command fields are captured on acceptance; later changes have no effect.
- State machine: IDLE -> SETUP -> STROBE -> HOLD, then either SETUP for the next write or IDLE.
  - IDLE: CMD_READY=1, DACS=1, DB_OE=0. CMD_VALID&CMD_READY captures the command and moves to SETUP.
  - SETUP, 1 cycle: AB and DB driven with the write's values, DB_OE=1, DACS=1.
  - STROBE, STROBE_LEN cycles: DACS=0; AB, DB and DB_OE held.
  - HOLD, 1 cycle: DACS=1; AB, DB and DB_OE held. The device latches on this rising DACS edge.
  - Leaving HOLD: if the write index is below the command's write count, increment and go to SETUP. Otherwise go to IDLE and pulse DONE.
- AB and DB change only on entry to SETUP, so they are stable across the whole strobe.

## Timing
- Reset values: CMD_READY=1, AB=4'h0, DB=8'h00, DB_OE=0, DACS=1, DONE=0, LOOPSH=2'b00, state IDLE, write index 0. Commands are ignored while RES=1.
- One write takes STROBE_LEN+2 cycles (4 at default).
- A START command spans 6*(STROBE_LEN+2) cycles from the first SETUP to the last HOLD (24 at default).
- Acceptance edge to first SETUP cycle: 1 cycle.
- DONE is asserted in the first IDLE cycle after the last HOLD. CMD_READY is also high in that cycle, so back-to-back commands leave exactly one idle cycle between them.
- CMD_READY=0 from the acceptance edge through the last HOLD. CMD_VALID during that period is not consumed.
- Reset asserted mid-command forces DACS=1 and DB_OE=0 asynchronously. The in-flight write may be latched by the device with partial data. LOOPSH clears; no DONE pulse is generated.

## Test plan
- Reset: assert RES mid-STROBE -> DACS=1 and DB_OE=0 in the same cycle; after release CMD_READY=1, AB=0, DB=0.
- START ch1, PITCH=12'hABC, MODE=2'b10, ADDR=17'h12345 -> AB/DB pairs 7/BC, 6/2A, 9/45, 8/23, 11/01, 10/00, each with DACS low for 2 cycles; DONE 25 cycles after acceptance.
- START ch0 then RETRIG ch0, CMD_VALID held high -> second command accepted in the DONE cycle; RETRIG write is AB=4, DB=00.
- LOOP ch1=1, then LOOP ch0=1, then LOOP ch1=0 -> register 13 (AB=12) written with 02, then 03, then 01.
- VOLUME with CMD_CH=1, CMD_VOL=8'h5A -> a single write AB=13, DB=5A.
- STROBE_LEN=1 build, START ch0 -> 18 cycles from first SETUP to last HOLD; DACS low exactly 1 cycle per write.
